// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// fetch_ctrl : instruction-fetch sequencer, one outstanding imem request,
//              valid/ready delivery to decode, redirect squash of in-flight fetch
// Revision   : 1.0
// ============================================================================
module fetch_ctrl #(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  redirect_valid,
   input  logic [DATA_WIDTH-1:0] redirect_target,
   output logic                  imem_req,
   output logic [DATA_WIDTH-1:0] imem_addr,
   input  logic                  imem_ready,
   input  logic                  imem_rvalid,
   input  logic [DATA_WIDTH-1:0] imem_rdata,
   output logic                  if_valid,
   input  logic                  if_ready,
   output logic [DATA_WIDTH-1:0] if_pc,
   output logic [DATA_WIDTH-1:0] if_instr
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_WAIT  = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] pc_q, pc_d;
   logic [DATA_WIDTH-1:0] req_pc_q, req_pc_d;
   logic [DATA_WIDTH-1:0] if_pc_q, if_pc_d;
   logic [DATA_WIDTH-1:0] if_instr_q, if_instr_d;
   logic                  kill_q, kill_d;
   logic                  valid_q, valid_d;

   logic [DATA_WIDTH-1:0] target;
   logic                  accept;
   logic                  unused_target_lsb;

   assign target            = {redirect_target[DATA_WIDTH-1:2], 2'b00};
   assign unused_target_lsb = ^redirect_target[1:0];

   // imem_req depends on state only, so no combinational path from handshake inputs
   assign imem_req  = (state_q == S_FETCH);
   assign imem_addr = pc_q;
   assign accept    = imem_req && imem_ready;
   assign if_valid  = valid_q;
   assign if_pc     = if_pc_q;
   assign if_instr  = if_instr_q;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      req_pc_d   = req_pc_q;
      kill_d     = kill_q;
      valid_d    = valid_q;
      if_pc_d    = if_pc_q;
      if_instr_d = if_instr_q;

      case (state_q)
         S_FETCH: begin
            if (accept) begin
               req_pc_d = pc_q;
               pc_d     = pc_q + DATA_WIDTH'(4);
               state_d  = S_WAIT;
               // request already left with the old pc; its response must be dropped
               kill_d   = redirect_valid;
            end
            if (redirect_valid) begin
               pc_d = target;
            end
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               if (kill_q || redirect_valid) begin
                  kill_d  = 1'b0;
                  state_d = S_FETCH;
               end else begin
                  if_instr_d = imem_rdata;
                  if_pc_d    = req_pc_q;
                  valid_d    = 1'b1;
                  state_d    = S_HOLD;
               end
            end else if (redirect_valid) begin
               kill_d = 1'b1;
            end
            if (redirect_valid) begin
               pc_d = target;
            end
         end
         S_HOLD: begin
            if (redirect_valid) begin
               valid_d = 1'b0;
               pc_d    = target;
               state_d = S_FETCH;
            end else if (if_ready) begin
               valid_d = 1'b0;
               state_d = S_FETCH;
            end
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_FETCH;
         pc_q       <= RESET_PC;
         req_pc_q   <= '0;
         kill_q     <= 1'b0;
         valid_q    <= 1'b0;
         if_pc_q    <= '0;
         if_instr_q <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_pc_q   <= req_pc_d;
         kill_q     <= kill_d;
         valid_q    <= valid_d;
         if_pc_q    <= if_pc_d;
         if_instr_q <= if_instr_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// tb_fetch_ctrl : scoreboard bench for fetch_ctrl with a latency-configurable imem
// Revision      : 1.0
// ============================================================================
module tb_fetch_ctrl;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          redirect_valid;
   logic [DW-1:0] redirect_target;
   logic          imem_req;
   logic [DW-1:0] imem_addr;
   logic          imem_ready;
   logic          imem_rvalid;
   logic [DW-1:0] imem_rdata;
   logic          if_valid;
   logic          if_ready;
   logic [DW-1:0] if_pc;
   logic [DW-1:0] if_instr;

   int tests = 0;
   int fails = 0;

   logic [2*DW-1:0] sb[$];
   logic [2*DW-1:0] sb_exp;

   int unsigned   mem_lat = 1;
   int unsigned   mem_cnt;
   logic [DW-1:0] mem_addr_q;

   fetch_ctrl #(.DATA_WIDTH(DW), .RESET_PC(32'h0000_0000)) dut (
      .clk             (clk),
      .rst             (rst),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .imem_req        (imem_req),
      .imem_addr       (imem_addr),
      .imem_ready      (imem_ready),
      .imem_rvalid     (imem_rvalid),
      .imem_rdata      (imem_rdata),
      .if_valid        (if_valid),
      .if_ready        (if_ready),
      .if_pc           (if_pc),
      .if_instr        (if_instr)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] mem_word(input logic [DW-1:0] a);
      return a * 32'd3 + 32'h1357_9BDF;
   endfunction

   // instruction memory: one response mem_lat cycles after each accept
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         imem_rvalid <= 1'b0;
         imem_rdata  <= '0;
         mem_cnt     <= 0;
         mem_addr_q  <= '0;
      end else begin
         imem_rvalid <= 1'b0;
         if (imem_req && imem_ready) begin
            if (mem_lat <= 1) begin
               imem_rvalid <= 1'b1;
               imem_rdata  <= mem_word(imem_addr);
            end else begin
               mem_cnt    <= mem_lat - 1;
               mem_addr_q <= imem_addr;
            end
         end else if (mem_cnt == 1) begin
            imem_rvalid <= 1'b1;
            imem_rdata  <= mem_word(mem_addr_q);
            mem_cnt     <= 0;
         end else if (mem_cnt > 1) begin
            mem_cnt <= mem_cnt - 1;
         end
      end
   end

   // decode-side monitor: every transfer is checked against the scoreboard
   always @(negedge clk) begin
      if (!rst && if_valid && if_ready) begin
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL xfer_unexpected: if_pc=%h if_instr=%h, required no transfer", if_pc, if_instr);
         end else begin
            sb_exp = sb.pop_front();
            if ({if_pc, if_instr} !== sb_exp) begin
               fails++;
               $display("FAIL xfer_data: if_pc=%h if_instr=%h, required if_pc=%h if_instr=%h",
                        if_pc, if_instr, sb_exp[2*DW-1:DW], sb_exp[DW-1:0]);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [DW-1:0] pc);
      sb.push_back({pc, mem_word(pc)});
   endtask

   task automatic do_reset(input logic rdy, input logic dec_rdy);
      rst             = 1'b1;
      redirect_valid  = 1'b0;
      redirect_target = '0;
      imem_ready      = rdy;
      if_ready        = dec_rdy;
      mem_lat         = 1;
      repeat (2) @(posedge clk);
      #1;
      sb.delete();
      rst = 1'b0;
   endtask

   task automatic wait_fetch(input logic [DW-1:0] addr, input string name);
      int n = 0;
      while (!(imem_req === 1'b1 && imem_addr === addr) && n < 40) begin
         step();
         n++;
      end
      tests++;
      if (!(imem_req === 1'b1 && imem_addr === addr)) begin
         fails++;
         $display("FAIL %s: imem_req=%b imem_addr=%h, required req=1 addr=%h", name, imem_req, imem_addr, addr);
      end
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (sb.size() != 0 && n < 40) begin
         step();
         n++;
      end
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL %s: %0d transfers outstanding, required 0", name, sb.size());
      end
   endtask

   task automatic test_reset();
      do_reset(1'b1, 1'b1);
      rst = 1'b1;
      step();
      tests++;
      if ({if_valid, if_pc, if_instr} !== {1'b0, 32'h0, 32'h0}) begin
         fails++;
         $display("FAIL reset_outputs: valid=%b pc=%h instr=%h, required 0/0/0", if_valid, if_pc, if_instr);
      end
      tests++;
      if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
         fails++;
         $display("FAIL reset_req: req=%b addr=%h, required req=1 addr=0", imem_req, imem_addr);
      end
   endtask

   task automatic test_sequential();
      do_reset(1'b1, 1'b1);
      push(32'h0); push(32'h4); push(32'h8);
      for (int k = 1; k <= 9; k++) begin
         step();
         tests++;
         if (if_valid !== ((k % 3) == 2)) begin
            fails++;
            $display("FAIL seq_valid_cycle%0d: if_valid=%b, required %b", k, if_valid, ((k % 3) == 2));
         end
      end
      wait_drain("seq_drain");
   endtask

   task automatic test_ready_stall();
      do_reset(1'b0, 1'b0);
      for (int k = 1; k <= 4; k++) begin
         step();
         tests++;
         if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
            fails++;
            $display("FAIL stall_req_cycle%0d: req=%b addr=%h, required req=1 addr=0", k, imem_req, imem_addr);
         end
      end
      push(32'h0);
      imem_ready = 1'b1;
      step();
      imem_ready = 1'b0;
      tests++;
      if (if_valid !== 1'b0) begin
         fails++;
         $display("FAIL stall_valid_early: if_valid=%b, required 0", if_valid);
      end
      step();
      tests++;
      if (if_valid !== 1'b1) begin
         fails++;
         $display("FAIL stall_valid_latency: if_valid=%b, required 1", if_valid);
      end
   endtask

   task automatic test_decode_stall();
      for (int k = 1; k <= 5; k++) begin
         step();
         tests++;
         if ({if_valid, if_pc, if_instr, imem_req} !== {1'b1, 32'h0, mem_word(32'h0), 1'b0}) begin
            fails++;
            $display("FAIL hold_stable_cycle%0d: valid=%b pc=%h instr=%h req=%b, required 1/0/%h/0",
                     k, if_valid, if_pc, if_instr, imem_req, mem_word(32'h0));
         end
      end
      if_ready = 1'b1;
      step();
      tests++;
      if ({if_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h4}) begin
         fails++;
         $display("FAIL hold_release: valid=%b req=%b addr=%h, required 0/1/4", if_valid, imem_req, imem_addr);
      end
      wait_drain("hold_drain");
   endtask

   task automatic test_redirect_wait();
      do_reset(1'b1, 1'b1);
      mem_lat = 3;
      step();
      redirect_valid  = 1'b1;
      redirect_target = 32'h0000_0103;
      step();
      redirect_valid  = 1'b0;
      push(32'h100);
      wait_fetch(32'h100, "rdw_next_addr");
      wait_drain("rdw_drain");
   endtask

   task automatic test_redirect_accept();
      do_reset(1'b1, 1'b1);
      push(32'h0); push(32'h4);
      wait_fetch(32'h8, "rda_reach8");
      redirect_valid  = 1'b1;
      redirect_target = 32'h0000_0200;
      step();
      redirect_valid  = 1'b0;
      tests++;
      if (imem_req !== 1'b0) begin
         fails++;
         $display("FAIL rda_wait_state: imem_req=%b, required 0", imem_req);
      end
      push(32'h200);
      wait_fetch(32'h200, "rda_next_addr");
      wait_drain("rda_drain");
      wait_fetch(32'h204, "rdr_reach204");
      step();
      redirect_valid  = 1'b1;
      redirect_target = 32'h0000_0200;
      step();
      redirect_valid  = 1'b0;
      tests++;
      if ({imem_req, imem_addr} !== {1'b1, 32'h200}) begin
         fails++;
         $display("FAIL rdr_next_addr: req=%b addr=%h, required req=1 addr=200", imem_req, imem_addr);
      end
      push(32'h200);
      wait_drain("rdr_drain");
   endtask

   task automatic test_redirect_hold();
      int n = 0;
      do_reset(1'b1, 1'b0);
      while (if_valid !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      tests++;
      if (if_valid !== 1'b1) begin
         fails++;
         $display("FAIL rdh_reach_hold: if_valid=%b, required 1", if_valid);
      end
      imem_ready      = 1'b0;
      redirect_valid  = 1'b1;
      redirect_target = 32'h0000_0300;
      step();
      redirect_valid  = 1'b0;
      tests++;
      if ({if_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h300}) begin
         fails++;
         $display("FAIL rdh_drop: valid=%b req=%b addr=%h, required 0/1/300", if_valid, imem_req, imem_addr);
      end
      push(32'h300);
      imem_ready = 1'b1;
      if_ready   = 1'b1;
      wait_drain("rdh_drain");
   endtask

   task automatic test_wrap();
      do_reset(1'b0, 1'b1);
      redirect_valid  = 1'b1;
      redirect_target = 32'hFFFF_FFFF;
      step();
      redirect_valid  = 1'b0;
      tests++;
      if ({imem_req, imem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
         fails++;
         $display("FAIL wrap_target: req=%b addr=%h, required req=1 addr=fffffffc", imem_req, imem_addr);
      end
      push(32'hFFFF_FFFC);
      imem_ready = 1'b1;
      wait_fetch(32'h0, "wrap_next_addr");
      imem_ready = 1'b0;
      wait_drain("wrap_drain");
   endtask

   task automatic test_reset_midwait();
      do_reset(1'b1, 1'b1);
      mem_lat = 3;
      push(32'h0); push(32'h4);
      wait_fetch(32'h8, "rst_reach8");
      step();
      tests++;
      if ({imem_req, if_valid, if_pc, if_instr} !== {1'b0, 1'b0, 32'h4, mem_word(32'h4)}) begin
         fails++;
         $display("FAIL rst_pre_state: req=%b valid=%b pc=%h instr=%h, required 0/0/4/%h",
                  imem_req, if_valid, if_pc, if_instr, mem_word(32'h4));
      end
      #2;
      rst = 1'b1;
      #1;
      tests++;
      if ({if_valid, if_pc, if_instr, imem_req, imem_addr} !== {1'b0, 32'h0, 32'h0, 1'b1, 32'h0}) begin
         fails++;
         $display("FAIL rst_async: valid=%b pc=%h instr=%h req=%b addr=%h, required 0/0/0/1/0",
                  if_valid, if_pc, if_instr, imem_req, imem_addr);
      end
      step();
      rst = 1'b0;
      push(32'h0);
      wait_drain("rst_restart");
   endtask

   initial begin
      rst             = 1'b1;
      redirect_valid  = 1'b0;
      redirect_target = '0;
      imem_ready      = 1'b1;
      if_ready        = 1'b1;
      test_reset();
      test_sequential();
      test_ready_stall();
      test_decode_stall();
      test_redirect_wait();
      test_redirect_accept();
      test_redirect_hold();
      test_wrap();
      test_reset_midwait();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
